world_arbiter: RTL
==================

WORLD_ARBITER -- requirements
Module: world_arbiter

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 run  in  1  level; 1 = let the automaton engine compute generations.
REQ-005 gen_limit  in  8  generations per run; 0 = unbounded.
REQ-006 eng_row, eng_col  in  6 each  engine cell address.
REQ-007 eng_we, eng_out  in  1 each  engine write enable and write data.
REQ-008 eng_update_done  in  1  engine one-cycle end-of-generation pulse.
REQ-009 eng_hold  out  1  1 = engine frozen, issuing no world accesses.
REQ-010 eng_in  out  1  world read data to engine.
REQ-011 host_req, host_we, host_wdata  in  1 each  host access request, write enable, write data.
REQ-012 host_row, host_col  in  6 each  host cell address.
REQ-013 host_gnt  out  1  host access accepted this cycle.
REQ-014 host_rdata, host_rvalid  out  1 each  read data and its valid strobe.
REQ-015 row, col  out  6 each  world address; world_we, world_out  out  1 each; world_in  in  1.
REQ-016 gen_count  out  16  generations completed since reset.
REQ-017 busy  out  1  1 in ENGINE state; done  out  1  one-cycle pulse when gen_limit is reached.

Function
REQ-018 The FSM SHALL have exactly two states: HOST (host owns world port, eng_hold=1) and ENGINE (engine owns port, eng_hold=0).
REQ-019 HOST->ENGINE SHALL occur on the edge where run=1 and host_req=0; host_req=1 blocks the transition (host wins simultaneous events).
REQ-020 ENGINE->HOST SHALL occur only on the edge where eng_update_done=1 and any of: run=0, host_req=1, limit reached (REQ-026); never mid-generation.
REQ-021 In ENGINE: row/col/world_we/world_out SHALL equal eng_* combinationally; eng_in=world_in; host_gnt=0.
REQ-022 In HOST: host_gnt=host_req (combinational); row/col=host_row/host_col; world_we=host_req&host_we; world_out=host_wdata; eng_in=0.
REQ-023 In HOST with host_req=0: world_we=0, row=col=0.
REQ-024 A granted read (host_we=0) SHALL register world_in into host_rdata with host_rvalid=1 on the next cycle (latency 1); host_rvalid=0 otherwise; host_rdata holds its last value.
REQ-025 One host access per cycle; back-to-back grants SHALL be supported.
REQ-026 Each eng_update_done in ENGINE SHALL increment gen_count (wraps 0xFFFF->0) and an internal 8-bit run counter; the run counter SHALL clear on each HOST->ENGINE transition; limit reached = gen_limit!=0 and run counter post-increment == gen_limit.
REQ-027 done SHALL pulse for one cycle, on the cycle after the update_done edge that reached the limit.
REQ-028 eng_update_done in HOST SHALL be ignored (no count).
REQ-029 busy SHALL be registered state (1 iff ENGINE).

Reset
REQ-030 rst=1 SHALL force HOST, eng_hold=1, gen_count=0, run counter=0, done=0, host_rvalid=0, host_rdata=0, busy=0 on the next edge, including mid-generation.
REQ-031 After reset, the engine SHALL be reset separately; the arbiter does not re-sequence a partial generation.

Configuration
REQ-032 Macro WORLD_ARBITER_GEN_LIMIT_EN: defined -> REQ-026 limit and done behave as above; undefined -> gen_limit is ignored, limit never reached, done tied to 0, port kept.

Verification
REQ-033 Reset, run=0, host writes (5,7)=1 then reads (5,7) -> host_gnt=1 both cycles, host_rvalid=1 with host_rdata=1 one cycle after read grant.
REQ-034 run=1, gen_limit=3, no host -> busy=1 next cycle, after 3rd update_done gen_count=3, done pulse once, eng_hold=1, busy=0.
REQ-035 ENGINE, host_req raised mid-generation -> host_gnt stays 0, world port follows engine until update_done, then HOST and host_gnt=1 next cycle.
REQ-036 run=1 and host_req=1 on same edge from HOST -> stays HOST, host served; ENGINE entered the cycle after host_req drops.
REQ-037 rst asserted mid-generation with gen_count=10 -> next cycle HOST, gen_count=0, eng_hold=1, done=0.
REQ-038 Macro undefined, gen_limit=2, run=1 for 4 generations -> gen_count=4, done never asserted, busy remains 1.

Source files
------------

// File: rtl/world_arbiter.sv
// Arbitrates the single-ported world memory between the host and the automaton engine.
// Optional generation limit and done pulse are enabled by defining WORLD_ARBITER_GEN_LIMIT_EN.
module world_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [7:0]  gen_limit,
    input  logic [5:0]  eng_row,
    input  logic [5:0]  eng_col,
    input  logic        eng_we,
    input  logic        eng_out,
    input  logic        eng_update_done,
    output logic        eng_hold,
    output logic        eng_in,
    input  logic        host_req,
    input  logic        host_we,
    input  logic        host_wdata,
    input  logic [5:0]  host_row,
    input  logic [5:0]  host_col,
    output logic        host_gnt,
    output logic        host_rdata,
    output logic        host_rvalid,
    output logic [5:0]  row,
    output logic [5:0]  col,
    output logic        world_we,
    output logic        world_out,
    input  logic        world_in,
    output logic [15:0] gen_count,
    output logic        busy,
    output logic        done
);

    typedef enum logic {HOST, ENGINE} state_t;

    state_t     state, state_nxt;
    logic [7:0] run_cnt;
    logic [7:0] run_cnt_inc;
    logic       gen_tick;
    logic       limit_hit;
    logic       host_read;

    assign run_cnt_inc = run_cnt + 8'd1;
    assign gen_tick    = (state == ENGINE) && eng_update_done;
    assign host_read   = host_gnt && !host_we;
    assign eng_hold    = (state == HOST);

`ifdef WORLD_ARBITER_GEN_LIMIT_EN
    logic done_r;

    assign limit_hit = (gen_limit != 8'd0) && (run_cnt_inc == gen_limit);
    assign done      = done_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= gen_tick && limit_hit;
        end
    end
`else
    logic unused_limit;

    assign limit_hit    = 1'b0;
    assign done         = 1'b0;
    assign unused_limit = ^{gen_limit, run_cnt};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HOST;
            busy        <= 1'b0;
            gen_count   <= '0;
            run_cnt     <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt == ENGINE);
            host_rvalid <= host_read;
            if (host_read) begin
                host_rdata <= world_in;
            end
            if (gen_tick) begin
                gen_count <= gen_count + 16'd1;
            end
            // A fresh run restarts the per-run count; counting only happens in ENGINE.
            if (state == HOST && state_nxt == ENGINE) begin
                run_cnt <= '0;
            end else if (gen_tick) begin
                run_cnt <= run_cnt_inc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        host_gnt  = 1'b0;
        row       = '0;
        col       = '0;
        world_we  = 1'b0;
        world_out = 1'b0;
        eng_in    = 1'b0;
        case (state)
            HOST: begin
                host_gnt  = host_req;
                world_we  = host_req && host_we;
                world_out = host_wdata;
                if (host_req) begin
                    row = host_row;
                    col = host_col;
                end
                if (run && !host_req) begin
                    state_nxt = ENGINE;
                end
            end
            ENGINE: begin
                row       = eng_row;
                col       = eng_col;
                world_we  = eng_we;
                world_out = eng_out;
                eng_in    = world_in;
                // Hand back only at a generation boundary.
                if (eng_update_done && (!run || host_req || limit_hit)) begin
                    state_nxt = HOST;
                end
            end
            default: state_nxt = HOST;
        endcase
    end

endmodule
